// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out for a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor walks the operands LSB first,
// producing a - b with final borrow and signed overflow after WIDTH RUN cycles.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;
    logic             busy_q;
    logic             done_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             a_msb_q;
    logic             b_msb_q;

    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_d;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign res_d = {d_bit, res_q[WIDTH-1:1]};
    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        res_q   <= '0;
                        bin_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    bin_q  <= bout_bit;
                    res_q  <= res_d;
                    cnt_q  <= cnt_d;
                    // Last bit pair: publish results directly from the combinational bit
                    if (cnt_q == LAST_STEP) begin
                        diff_q   <= res_d;
                        borrow_q <= bout_bit;
                        ovf_q    <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor with an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    logic fa = 1'b0, fb = 1'b0, fbin = 1'b0;
    logic fd, fbout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_diff = '0;
    logic         last_bor  = 1'b0;
    logic         last_ovf  = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    full_subtractor u_fs_tt (
        .a    (fa),
        .b    (fb),
        .bin  (fbin),
        .d    (fd),
        .bout (fbout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands
    task automatic ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] e_diff, output logic e_bor, output logic e_ovf);
        int ux, uy, sx, sy, sr;
        ux     = int'(x);
        uy     = int'(y);
        sx     = int'($signed(x));
        sy     = int'($signed(y));
        sr     = sx - sy;
        e_diff = W'(ux - uy);
        e_bor  = (ux < uy);
        e_ovf  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'd0);
        chk({tag, "_borrow"}, 32'(borrow_out), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit scramble);
        logic [W-1:0] ed;
        logic         eb, eo;
        ref_sub(x, y, ed, eb, eo);
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("diff_hold_run", 32'(diff), 32'(last_diff));
            if (scramble) begin
                a     = W'($urandom);
                b     = W'($urandom);
                start = (i < W) ? 1'($urandom) : 1'b0;
            end
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("diff", 32'(diff), 32'(ed));
        chk("borrow_out", 32'(borrow_out), 32'(eb));
        chk("ovf", 32'(ovf), 32'(eo));
        last_diff = ed;
        last_bor  = eb;
        last_ovf  = eo;
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("diff_hold_idle", 32'(diff), 32'(ed));
        chk("borrow_hold_idle", 32'(borrow_out), 32'(eb));
        chk("ovf_hold_idle", 32'(ovf), 32'(eo));
    endtask

    initial begin
        int n_done, first_c, second_c, r;

        // Full-subtractor truth table against a - b - bin
        for (int v = 0; v < 8; v++) begin
            {fa, fb, fbin} = 3'(v);
            #1;
            r = int'(fa) - int'(fb) - int'(fbin);
            chk("fs_d", 32'(fd), 32'(r & 1));
            chk("fs_bout", 32'(fbout), 32'(r < 0));
        end

        rst_n = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b1);
        run_op(8'h80, 8'h01, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b1);

        // Back-to-back with start held high
        a        = 8'hFF;
        b        = 8'h01;
        start    = 1'b1;
        n_done   = 0;
        first_c  = 0;
        second_c = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 1) begin
                a = 8'h00;
                b = 8'h00;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_c = c;
                    chk("b2b_diff1", 32'(diff), 32'h0FE);
                    chk("b2b_borrow1", 32'(borrow_out), 32'd0);
                    chk("b2b_ovf1", 32'(ovf), 32'd0);
                end else if (n_done == 2) begin
                    second_c = c;
                    chk("b2b_diff2", 32'(diff), 32'h000);
                    chk("b2b_borrow2", 32'(borrow_out), 32'd0);
                    chk("b2b_ovf2", 32'(ovf), 32'd0);
                end
            end
            if (c == 19) start = 1'b0;
        end
        chk("b2b_done_count", 32'(n_done), 32'd2);
        chk("b2b_first_latency", 32'(first_c), 32'(W + 1));
        chk("b2b_period", 32'(second_c - first_c), 32'(W + 2));
        last_diff = '0;
        last_bor  = 1'b0;
        last_ovf  = 1'b0;

        // Reset in RUN cycle 4 aborts with no done pulse
        a     = 8'h55;
        b     = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check_zero("abort");
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done || busy) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        run_op(8'h10, 8'h01, 1'b0);

        // Reset wins over start in the same cycle
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        tick();
        check_zero("rst_prio");
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        chk("rst_prio_idle", 32'(busy), 32'd0);
        last_diff = '0;
        last_bor  = 1'b0;
        last_ovf  = 1'b0;

        for (int n = 0; n < 20; n++) begin
            run_op(W'($urandom), W'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range 2..32.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-004 Port start, input, 1 bit, SHALL request a subtraction; it is sampled only in IDLE.
REQ-005 Port a, input, WIDTH bits, SHALL carry the minuend; it is captured when start is accepted.
REQ-006 Port b, input, WIDTH bits, SHALL carry the subtrahend; it is captured when start is accepted.
REQ-007 Port busy, output, 1 bit, SHALL be high while the FSM is in RUN.
REQ-008 Port done, output, 1 bit, SHALL pulse high for one cycle when a result becomes valid.
REQ-009 Port diff, output, WIDTH bits, SHALL carry the result a-b, modulo 2^WIDTH.
REQ-010 Port borrow_out, output, 1 bit, SHALL be the final borrow: 1 iff unsigned a < b.
REQ-011 Port ovf, output, 1 bit, SHALL flag signed (two's-complement) overflow of a-b.

Function
REQ-012 The FSM SHALL have three states:
- IDLE: start=1 goes to RUN; otherwise stay in IDLE.
- RUN: stay until WIDTH bit-steps are complete, then go to DONE.
- DONE: go to IDLE unconditionally.
REQ-013 On the accepting edge, the block SHALL:
- load a and b into internal shift registers;
- clear the running borrow;
- clear the bit counter to 0.
REQ-014 Each RUN cycle SHALL process exactly one bit pair, LSB first:
- d = ai ^ bi ^ bin;
- bout = (~ai & bi) | (~(ai ^ bi) & bin);
- bout is registered as the next bin;
- d is shifted into the result register from the MSB end.
REQ-015 Latency is fixed:
- start accepted at edge k;
- busy high in cycles k+1 .. k+WIDTH;
- done high in cycle k+WIDTH+1 only.
REQ-016 diff, borrow_out and ovf SHALL update on the edge entering DONE and hold until the next accepted start. Between acceptance and DONE they are don't-care, but they SHALL NOT glitch visibly outside RUN.
REQ-017 ovf SHALL equal (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), using the captured operands.
REQ-018 start while in RUN or DONE SHALL be ignored; no queuing, and the result is unaffected.
REQ-019 a and b changing after acceptance SHALL NOT affect the result.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.
REQ-021 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle following DONE, giving a minimum period of WIDTH+2 cycles.

Reset
REQ-022 With rst_n=0 at a clock edge, the block SHALL:
- go to IDLE;
- clear busy, done, diff, borrow_out, ovf, the running borrow, the counter and both shift registers.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after reset release SHALL behave per REQ-013.
REQ-024 Reset SHALL take priority over start in the same cycle.

Structure
REQ-025 Shared package serial_sub_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the default WIDTH constant.
REQ-026 The one-bit difference/borrow logic SHALL be a combinational sub-module, full_subtractor, with ports a, b, bin, d, bout, instantiated once.
REQ-027 The datapath SHALL be bit-serial (one full_subtractor) and SHALL NOT contain a WIDTH-bit parallel subtractor.

Verification
REQ-028 The bench SHALL cover these directed scenarios (WIDTH=8):
- a=5, b=3, start for 1 cycle -> busy high for 8 cycles; done in cycle 9; diff=0x02, borrow_out=0, ovf=0.
- a=3, b=5 -> diff=0xFE, borrow_out=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1.
- start held high across two operations (0xFF-0x01, then 0x00-0x00) -> results 0xFE then 0x00; done pulses exactly WIDTH+2 cycles apart; mid-run start pulses have no effect.
- rst_n low in RUN cycle 4 -> no done; all outputs 0 the next cycle; a following 0x10-0x01 gives 0x0F.
REQ-029 The bench SHALL exhaustively cover the full_subtractor truth table (8 input combinations) against d and bout.
